ofmap_bit_packer: RTL and testbench
===================================

// Module: ofmap_bit_packer
// PURPOSE
//  Downstream neighbour of the psum adder/threshold stage. Collects the 1-bit binarized
//  activations it emits (o_data/address_out/o_valid) and packs them into WORD_WIDTH-bit
//  masked writes to the ofmaps BRAM. Tracks a per-layer output count and signals done
//  once the last bit has been committed.
// PARAMETERS
//  OFMAPS_BRAM_ADDR_WIDTH  12  bit address width of incoming activations
//  WORD_WIDTH              32  BRAM word width in bits (power of 2, >= 2)
//  BIT_SEL_WIDTH           5   log2(WORD_WIDTH); low bits of i_addr select the bit in a word
//  CNT_WIDTH               16  width of the output-bit counter and cfg_total
// PORTS
//  clk          in   1    clock; all logic is on the rising edge
//  rst          in   1    asynchronous, active-high reset
//  start        in   1    pulse: latch cfg_total, clear counter/err/accumulator, enter RUN
//  cfg_total    in   CNT_WIDTH  number of activation bits expected this layer
//  i_data       in   1    activation bit (from the adder's o_data)
//  i_addr       in   OFMAPS_BRAM_ADDR_WIDTH  bit address (from the adder's address_out)
//  i_valid      in   1    beat qualifier (from the adder's o_valid); no backpressure
//  flush        in   1    pulse: commit the partial word now; the run continues
//  bram_we      out  1    BRAM write enable, registered
//  bram_addr    out  OFMAPS_BRAM_ADDR_WIDTH-BIT_SEL_WIDTH  word address = i_addr[MSB:BIT_SEL_WIDTH]
//  bram_wdata   out  WORD_WIDTH  packed bits; bits outside the mask are 0
//  bram_wmask   out  WORD_WIDTH  per-bit write mask
//  busy         out  1    state != IDLE
//  done         out  1    one-cycle pulse, high while state == DONE
//  err          out  1    sticky: i_valid seen outside RUN; cleared by start
// BEHAVIOUR
//  - Reset: state IDLE; every output, the accumulator (acc_data, acc_mask, acc_waddr,
//    acc_valid), the counter and the pending-flush flag are 0. Asynchronous assert
//    mid-run drops the partial word. No write is issued after release.
//  - FSM: IDLE -start-> RUN (FLUSH if cfg_total==0); RUN -final beat-> FLUSH; FLUSH -> DONE;
//    DONE -> IDLE. A start in any state restarts: it discards the accumulator with no
//    write and clears the counter and err. A start in the same cycle as i_valid drops
//    the beat.
//  - RUN beat (i_valid=1): word = i_addr[MSB:BIT_SEL_WIDTH], bit = i_addr[BIT_SEL_WIDTH-1:0].
//    * acc_valid && word != acc_waddr: write the old acc. The new acc holds only this bit.
//    * otherwise: set acc_data[bit]=i_data and acc_mask[bit]=1. On a repeated bit the
//      last value wins. If the mask becomes all ones, write the acc and clear acc_valid.
//    * The counter increments on every RUN beat. The beat that makes count==cfg_total
//      is the final beat.
//  - Write timing: bram_we/addr/wdata/wmask are registered. They appear the cycle after
//    the triggering event, for exactly 1 cycle, with at most one write per cycle.
//  - FLUSH state (1 cycle): if acc_valid, write the acc and clear it.
//    done=1 in the following cycle (DONE).
//    Final beat at cycle N: its own write (if any) at N+1, residual write at N+2, done at N+2.
//  - flush input in RUN: commit the acc if acc_valid; no write if the acc is empty.
//    If flush and i_valid arrive together, the beat is processed and the flush is
//    deferred one cycle. flush outside RUN is ignored.
//  - i_valid outside RUN (IDLE/FLUSH/DONE): the beat is dropped and err is set.
//  - Widths: the counter wraps only if cfg_total > 2^CNT_WIDTH-1 (not allowed by config).
// TESTING
//  1. start, cfg_total=32; addrs 0..31, data 1,0,1,0.. -> at N+1 one write: addr 0,
//     wdata 0x55555555, wmask 0xFFFFFFFF; no FLUSH write; done at N+2.
//  2. cfg_total=3; addr 30,31 (1,1) then addr 64 (1) -> write addr0 wd 0xC0000000
//     wm 0xC0000000 at N+1; write addr2 wd 0x1 wm 0x1 at N+2; done at N+2.
//  3. addrs 0..4 all 1, then flush pulse -> write addr0 wd 0x1F wm 0x1F; busy stays 1.
//     flush together with the 5th beat -> the write lands one cycle later.
//  4. i_valid pulses while IDLE -> err=1, bram_we stays 0; next start -> err=0.
//  5. rst asserted after 7 beats into word 3 -> outputs 0 at once; after release no
//     write, busy=0, done never pulses.
//  6. start with cfg_total=0 -> FLUSH, then done=1 two cycles after start; no BRAM write.

Source files
------------

// File: rtl/ofmap_bit_packer_if.sv
// Masked word-write port from the bit packer to the ofmaps BRAM.
// The packer drives it through the master modport, and the BRAM side reads it through the slave modport.
interface ofmap_bit_packer_if #(
    parameter int unsigned WADDR_WIDTH = 7,
    parameter int unsigned WORD_WIDTH  = 32
);
    logic                   bram_we;
    logic [WADDR_WIDTH-1:0] bram_addr;
    logic [WORD_WIDTH-1:0]  bram_wdata;
    logic [WORD_WIDTH-1:0]  bram_wmask;

    modport master (output bram_we, output bram_addr, output bram_wdata, output bram_wmask);
    modport slave  (input  bram_we, input  bram_addr, input  bram_wdata, input  bram_wmask);
endinterface

// File: rtl/ofmap_bit_packer.sv
// Packs binarized activation bits into masked BRAM word writes.
// It counts the bits of each layer and pulses done after the last word has been committed.
module ofmap_bit_packer #(
    parameter int unsigned OFMAPS_BRAM_ADDR_WIDTH = 12,
    parameter int unsigned WORD_WIDTH             = 32,
    parameter int unsigned BIT_SEL_WIDTH          = 5,
    parameter int unsigned CNT_WIDTH              = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CNT_WIDTH-1:0]              cfg_total,
    input  logic                              i_data,
    input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] i_addr,
    input  logic                              i_valid,
    input  logic                              flush,
    ofmap_bit_packer_if.master                bram,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
    localparam int unsigned WaddrWidth = OFMAPS_BRAM_ADDR_WIDTH - BIT_SEL_WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, total_q, total_d;
    logic                    err_q, err_d, pend_q, pend_d;
    logic [WORD_WIDTH-1:0]   acc_data_q, acc_data_d, acc_mask_q, acc_mask_d;
    logic [WaddrWidth-1:0]   acc_waddr_q, acc_waddr_d;
    logic                    acc_valid_q, acc_valid_d;
    logic                    we_q, we_d;
    logic [WaddrWidth-1:0]   waddr_q, waddr_d;
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d, wmask_q, wmask_d;

    logic [WaddrWidth-1:0]    beat_word;
    logic [BIT_SEL_WIDTH-1:0] beat_bit;
    logic [WORD_WIDTH-1:0]    onehot;

    assign beat_word = i_addr[OFMAPS_BRAM_ADDR_WIDTH-1:BIT_SEL_WIDTH];
    assign beat_bit  = i_addr[BIT_SEL_WIDTH-1:0];
    assign onehot    = {{(WORD_WIDTH-1){1'b0}}, 1'b1} << beat_bit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        err_d       = err_q;
        pend_d      = pend_q;
        acc_data_d  = acc_data_q;
        acc_mask_d  = acc_mask_q;
        acc_waddr_d = acc_waddr_q;
        acc_valid_d = acc_valid_q;
        we_d        = 1'b0;
        waddr_d     = '0;
        wdata_d     = '0;
        wmask_d     = '0;
        if (start) begin
            // Restart from any state: the partial word is discarded, never written.
            total_d     = cfg_total;
            cnt_d       = '0;
            err_d       = 1'b0;
            pend_d      = 1'b0;
            acc_data_d  = '0;
            acc_mask_d  = '0;
            acc_waddr_d = '0;
            acc_valid_d = 1'b0;
            state_d     = (cfg_total == '0) ? StFlush : StRun;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    if (i_valid) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (acc_valid_q && beat_word != acc_waddr_q) begin
                            we_d       = 1'b1;
                            waddr_d    = acc_waddr_q;
                            wdata_d    = acc_data_q;
                            wmask_d    = acc_mask_q;
                            acc_data_d = i_data ? onehot : '0;
                            acc_mask_d = onehot;
                        end else begin
                            acc_data_d = (acc_data_q & ~onehot) | (i_data ? onehot : '0);
                            acc_mask_d = acc_mask_q | onehot;
                        end
                        acc_waddr_d = beat_word;
                        acc_valid_d = 1'b1;
                        if (&acc_mask_d) begin
                            we_d        = 1'b1;
                            waddr_d     = beat_word;
                            wdata_d     = acc_data_d;
                            wmask_d     = acc_mask_d;
                            acc_data_d  = '0;
                            acc_mask_d  = '0;
                            acc_valid_d = 1'b0;
                        end
                        // A flush that collides with a beat is deferred to a beat-free cycle.
                        if (flush) pend_d = 1'b1;
                        if (cnt_d == total_q) begin
                            state_d = StFlush;
                            pend_d  = 1'b0;
                        end
                    end else if (flush || pend_q) begin
                        pend_d = 1'b0;
                        if (acc_valid_q) begin
                            we_d        = 1'b1;
                            waddr_d     = acc_waddr_q;
                            wdata_d     = acc_data_q;
                            wmask_d     = acc_mask_q;
                            acc_data_d  = '0;
                            acc_mask_d  = '0;
                            acc_valid_d = 1'b0;
                        end
                    end
                end
                StFlush: begin
                    if (acc_valid_q) begin
                        we_d        = 1'b1;
                        waddr_d     = acc_waddr_q;
                        wdata_d     = acc_data_q;
                        wmask_d     = acc_mask_q;
                        acc_data_d  = '0;
                        acc_mask_d  = '0;
                        acc_valid_d = 1'b0;
                    end
                    state_d = StDone;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
            if (i_valid && state_q != StRun) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            total_q     <= '0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            acc_data_q  <= '0;
            acc_mask_q  <= '0;
            acc_waddr_q <= '0;
            acc_valid_q <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            acc_data_q  <= acc_data_d;
            acc_mask_q  <= acc_mask_d;
            acc_waddr_q <= acc_waddr_d;
            acc_valid_q <= acc_valid_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
        end
    end

    assign bram.bram_we    = we_q;
    assign bram.bram_addr  = waddr_q;
    assign bram.bram_wdata = wdata_q;
    assign bram.bram_wmask = wmask_q;
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign err             = err_q;
endmodule

// File: tb/tb_ofmap_bit_packer.sv
// Bench for ofmap_bit_packer: directed scenarios plus random runs, checked every cycle
// against a word-grouping reference model that tracks the collected bits individually.
module tb_ofmap_bit_packer;
    localparam int AW  = 12;
    localparam int WW  = 32;
    localparam int BSW = 5;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_total = '0;
    logic          i_data = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_valid = 1'b0;
    logic          flush = 1'b0;
    logic          busy, done, err;

    ofmap_bit_packer_if #(.WADDR_WIDTH(AW - BSW), .WORD_WIDTH(WW)) bram ();

    ofmap_bit_packer #(
        .OFMAPS_BRAM_ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BIT_SEL_WIDTH(BSW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_total(cfg_total), .i_data(i_data),
        .i_addr(i_addr), .i_valid(i_valid), .flush(flush), .bram(bram),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 collecting, 2 final commit, 3 done
    int          m_phase = 0;
    int          m_left  = 0;
    int          m_word  = 0;
    bit          m_err   = 1'b0;
    bit          m_owed  = 1'b0;
    int          m_bits[WW];
    bit          exp_we;
    logic [31:0] exp_addr, exp_data, exp_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < WW; i++) m_bits[i] = -1;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < WW; i++) if (m_bits[i] >= 0) c++;
        return c;
    endfunction

    task automatic m_emit();
        exp_we   = 1'b1;
        exp_addr = m_word;
        exp_data = '0;
        exp_mask = '0;
        for (int i = 0; i < WW; i++) begin
            if (m_bits[i] >= 0) begin
                exp_mask[i] = 1'b1;
                exp_data[i] = (m_bits[i] == 1);
            end
        end
        m_clear();
    endtask

    task automatic m_reset();
        m_phase = 0; m_left = 0; m_word = 0; m_err = 1'b0; m_owed = 1'b0; exp_we = 1'b0;
        m_clear();
    endtask

    task automatic model_step(input bit v, input bit d, input int a, input bit f, input bit s,
                              input int tot);
        int ph0 = m_phase;
        int w   = a / WW;
        int b   = a % WW;
        exp_we = 1'b0;
        if (s) begin
            m_clear();
            m_left  = tot;
            m_err   = 1'b0;
            m_owed  = 1'b0;
            m_phase = (tot == 0) ? 2 : 1;
        end else begin
            if (ph0 == 1) begin
                if (v) begin
                    m_left--;
                    if (m_count() > 0 && w != m_word) m_emit();
                    m_word    = w;
                    m_bits[b] = d;
                    if (m_count() == WW) m_emit();
                    if (f) m_owed = 1'b1;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_owed  = 1'b0;
                    end
                end else if (f || m_owed) begin
                    m_owed = 1'b0;
                    if (m_count() > 0) m_emit();
                end
            end else if (ph0 == 2) begin
                if (m_count() > 0) m_emit();
                m_phase = 3;
            end else if (ph0 == 3) begin
                m_phase = 0;
            end
            if (v && ph0 != 1) m_err = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("bram_we", 32'(bram.bram_we), 32'(exp_we));
        if (exp_we) begin
            check("bram_addr", 32'(bram.bram_addr), exp_addr);
            check("bram_wdata", bram.bram_wdata, exp_data);
            check("bram_wmask", bram.bram_wmask, exp_mask);
        end
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done", 32'(done), 32'(m_phase == 3));
        check("err", 32'(err), 32'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input bit v, input bit d, input int a, input bit f, input bit s,
                        input int tot);
        i_valid   = v;
        i_data    = d;
        i_addr    = a[AW-1:0];
        flush     = f;
        start     = s;
        cfg_total = tot[CW-1:0];
        model_step(v, d, a, f, s, tot);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic beat(input int a, input bit d, input bit f);
        step(1'b1, d, a, f, 1'b0, 0);
    endtask

    task automatic do_start(input int tot);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, tot);
    endtask

    initial begin
        int addr_ptr;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        idle(2);

        // 1: one full word, written straight from the final beat
        do_start(32);
        for (int i = 0; i < 32; i++) beat(i, (i % 2) == 0, 1'b0);
        check("t1_wdata", bram.bram_wdata, 32'h5555_5555);
        check("t1_wmask", bram.bram_wmask, 32'hFFFF_FFFF);
        idle(1);
        check("t1_done", 32'(done), 32'd1);
        idle(2);

        // 2: a word change writes the old word, and the residual word is written in FLUSH
        do_start(3);
        beat(30, 1'b1, 1'b0);
        beat(31, 1'b1, 1'b0);
        beat(64, 1'b1, 1'b0);
        check("t2_wdata0", bram.bram_wdata, 32'hC000_0000);
        idle(1);
        check("t2_addr1", 32'(bram.bram_addr), 32'd2);
        check("t2_wdata1", bram.bram_wdata, 32'h0000_0001);
        idle(2);

        // 3: explicit flush, then a flush that collides with a beat
        do_start(100);
        for (int i = 0; i < 5; i++) beat(i, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        check("t3_wdata", bram.bram_wdata, 32'h0000_001F);
        for (int i = 0; i < 5; i++) beat(32 + i, 1'b1, i == 4);
        check("t3_defer_we", 32'(bram.bram_we), 32'd0);
        idle(1);
        check("t3_late_wmask", bram.bram_wmask, 32'h0000_001F);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        do_start(0);
        idle(3);

        // 4: beats while idle set err, and the next start clears it
        beat(5, 1'b1, 1'b0);
        beat(6, 1'b0, 1'b0);
        check("t4_err", 32'(err), 32'd1);
        do_start(4);
        check("t4_err_clr", 32'(err), 32'd0);

        // 5: asynchronous reset in the middle of word 3
        do_start(50);
        for (int i = 0; i < 7; i++) beat(96 + i, 1'b1, 1'b0);
        i_valid = 1'b0;
        rst     = 1'b1;
        #1;
        m_reset();
        check("t5_busy_async", 32'(busy), 32'd0);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // 6: an empty layer reaches DONE without writing
        do_start(0);
        idle(3);

        // Random runs: mostly sequential addresses, with jumps, repeats, gaps and flushes
        for (int r = 0; r < 25; r++) begin
            int guard = 0;
            do_start($urandom_range(1, 70));
            addr_ptr = $urandom_range(0, 4000);
            while (m_phase == 1 && guard < 400) begin
                int p = $urandom_range(0, 99);
                guard++;
                if (p < 12) begin
                    step(1'b0, 1'b0, 0, $urandom_range(0, 99) < 20, 1'b0, 0);
                end else begin
                    if (p < 22) addr_ptr = $urandom_range(0, 4095);
                    else if (p >= 30) addr_ptr = (addr_ptr + 1) % 4096;
                    beat(addr_ptr, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 8);
                end
                if ($urandom_range(0, 299) == 0) do_start($urandom_range(1, 40));
            end
            for (int k = 0; k < 3; k++) step($urandom_range(0, 3) == 0, 1'b1, 0, 1'b0, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
